muldiv_unit: RTL

- Parametrised iterative multiply/divide unit that owns the Hi/Lo register pair.
- Successor to the single-cycle mult path in the ALU and the standalone Hi/Lo registers. Adds signed and unsigned divide, multiply-accumulate and multiply-subtract, a busy/done handshake and a pipeline-flush cancel.
- Sits in EX beside the ALU. The top-level hazard logic stalls MFHI/MFLO and new mul/div ops while Busy is high.

---
 rtl/muldiv_pkg.sv | 45 ++++
 rtl/muldiv_core.sv | 57 +++++
 rtl/muldiv_unit.sv | 131 +++++++++++++
 3 files changed

// File: rtl/muldiv_pkg.sv
// Shared types and op classification helpers for the iterative multiply/divide unit.
package muldiv_pkg;

    typedef enum logic [3:0] {
        NOP   = 4'd0,
        MULT  = 4'd1,
        MULTU = 4'd2,
        DIV   = 4'd3,
        DIVU  = 4'd4,
        MADD  = 4'd5,
        MADDU = 4'd6,
        MSUB  = 4'd7,
        MSUBU = 4'd8,
        MTHI  = 4'd9,
        MTLO  = 4'd10
    } op_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIX  = 2'd2
    } state_t;

    function automatic logic is_div(op_t op);
        return (op == DIV) || (op == DIVU);
    endfunction

    function automatic logic is_signed(op_t op);
        return (op == MULT) || (op == DIV) || (op == MADD) || (op == MSUB);
    endfunction

    function automatic logic is_acc(op_t op);
        return (op == MADD) || (op == MADDU) || (op == MSUB) || (op == MSUBU);
    endfunction

    function automatic logic is_sub(op_t op);
        return (op == MSUB) || (op == MSUBU);
    endfunction

    // Ops that run the full iterative sequence and end with a Done pulse.
    function automatic logic is_long(op_t op);
        return (op >= MULT) && (op <= MSUBU);
    endfunction

endpackage

// File: rtl/muldiv_core.sv
// One-bit-per-cycle datapath: radix-2 shift-add multiply or restoring divide on unsigned magnitudes.
module muldiv_core
    import muldiv_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic                 Clk,
    input  logic                 Rst,
    input  logic                 load_i,
    input  logic                 step_i,
    input  logic                 div_i,
    input  logic [WIDTH-1:0]     lo_i,
    input  logic [WIDTH-1:0]     opb_i,
    output logic [2*WIDTH-1:0]   acc_o
);

    logic [2*WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0]   opb_q;
    logic               div_q;
    logic [WIDTH:0]     sum, shifted, diff;

    // Multiply: low half holds the multiplier and shifts right under the growing product.
    // Divide: {remainder, dividend} shifts left and quotient bits enter at the bottom.
    always_comb begin
        sum     = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, opb_q} : '0);
        shifted = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
        diff    = shifted - {1'b0, opb_q};
        acc_d   = acc_q;
        if (load_i) begin
            acc_d = {{WIDTH{1'b0}}, lo_i};
        end else if (step_i) begin
            if (div_q) begin
                acc_d = diff[WIDTH] ? {shifted[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0}
                                    : {diff[WIDTH-1:0],    acc_q[WIDTH-2:0], 1'b1};
            end else begin
                acc_d = {sum, acc_q[WIDTH-1:1]};
            end
        end
    end

    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            acc_q <= '0;
            opb_q <= '0;
            div_q <= 1'b0;
        end else begin
            acc_q <= acc_d;
            if (load_i) begin
                opb_q <= opb_i;
                div_q <= div_i;
            end
        end
    end

    assign acc_o = acc_q;

endmodule

// File: rtl/muldiv_unit.sv
// Iterative multiply/divide unit owning Hi/Lo: FSM, iteration counter, flush, sign fix-up and commit.
module muldiv_unit
    import muldiv_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             Clk,
    input  logic             Rst,
    input  logic             Start,
    input  logic [3:0]       Op,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             Flush,
    output logic             Busy,
    output logic             Done,
    output logic             DivZero,
    output logic [WIDTH-1:0] Hi,
    output logic [WIDTH-1:0] Lo
);

    localparam int CNT_W = $clog2(WIDTH) + 1;

    state_t             state_q;
    op_t                op_q;
    logic [CNT_W-1:0]   cnt_q;
    logic [WIDTH-1:0]   a_q, b_q, hi_q, lo_q;
    logic               busy_q, done_q, dz_q;

    op_t                op_in;
    logic               load, op_neg, div_zero;
    logic [WIDTH-1:0]   a_mag, b_mag, quot, rem;
    logic [2*WIDTH-1:0] acc, prod, fix;

    assign op_in = op_t'(Op);
    assign load  = (state_q == IDLE) && Start && !Flush && is_long(op_in);
    assign a_mag = (is_signed(op_in) && A[WIDTH-1]) ? -A : A;
    assign b_mag = (is_signed(op_in) && B[WIDTH-1]) ? -B : B;

    muldiv_core #(.WIDTH(WIDTH)) u_core (
        .Clk    (Clk),
        .Rst    (Rst),
        .load_i (load),
        .step_i (state_q == RUN),
        .div_i  (is_div(op_in)),
        .lo_i   (is_div(op_in) ? a_mag : b_mag),
        .opb_i  (is_div(op_in) ? b_mag : a_mag),
        .acc_o  (acc)
    );

    // Hi/Lo cannot change while busy, so they still hold the value seen at Start.
    always_comb begin
        op_neg   = is_signed(op_q) && (a_q[WIDTH-1] ^ b_q[WIDTH-1]);
        div_zero = is_div(op_q) && (b_q == '0);
        prod     = op_neg ? -acc : acc;
        quot     = op_neg ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
        rem      = (is_signed(op_q) && a_q[WIDTH-1]) ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];
        fix      = prod;
        if (is_div(op_q)) begin
            fix = div_zero ? {a_q, {WIDTH{1'b1}}} : {rem, quot};
        end else if (is_acc(op_q)) begin
            fix = is_sub(op_q) ? ({hi_q, lo_q} - prod) : ({hi_q, lo_q} + prod);
        end
    end

    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            state_q <= IDLE;
            op_q    <= NOP;
            cnt_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            dz_q    <= 1'b0;
        end else begin
            done_q <= 1'b0;
            dz_q   <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (Start && !Flush) begin
                        if (is_long(op_in)) begin
                            state_q <= RUN;
                            op_q    <= op_in;
                            a_q     <= A;
                            b_q     <= B;
                            cnt_q   <= '0;
                            busy_q  <= 1'b1;
                        end else if (op_in == MTHI) begin
                            hi_q <= A;
                        end else if (op_in == MTLO) begin
                            lo_q <= A;
                        end
                    end
                end
                RUN: begin
                    if (Flush) begin
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                        if (cnt_q == CNT_W'(WIDTH - 1)) begin
                            state_q <= FIX;
                        end
                    end
                end
                FIX: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                    if (!Flush) begin
                        {hi_q, lo_q} <= fix;
                        done_q       <= 1'b1;
                        dz_q         <= div_zero;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign Busy    = busy_q;
    assign Done    = done_q;
    assign DivZero = dz_q;
    assign Hi      = hi_q;
    assign Lo      = lo_q;

endmodule
